// File: rtl/axil_sram_slave.sv
// AXI4-Lite responder backed by a word-addressed SRAM, with independent read and
// write FSMs and programmable response latency on each channel.
module axil_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1,
  parameter int WR_LAT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);
  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both high; a raised valid holds with a stable payload
  // until that edge.
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = $clog2(DEPTH_WORDS);
  localparam int RCW    = $clog2(RD_LAT) + 1;
  localparam int WCW    = $clog2(WR_LAT) + 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  r_state_t         r_state;
  w_state_t         w_state;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] r_idx;
  logic [RCW-1:0]   r_cnt;
  logic [IDX_W-1:0] w_idx;
  logic [WCW-1:0]   w_cnt;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             aw_got;
  logic             w_got;
  logic             aw_now;
  logic             w_now;
  logic             r_in_range;
  logic             w_in_range;
  logic             commit;
  logic             unused_ok;

  assign r_in_range = (r_idx >> MEM_AW) == '0;
  assign w_in_range = (w_idx >> MEM_AW) == '0;
  assign aw_now     = aw_got | (awvalid & awready);
  assign w_now      = w_got | (wvalid & wready);
  assign commit     = (w_state == W_WAIT) && (w_cnt == '0) && w_in_range;
  assign unused_ok  = ^{araddr[1:0], awaddr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_idx   <= araddr[ADDR_WIDTH-1:2];
            r_cnt   <= RCW'(RD_LAT - 1);
            arready <= 1'b0;
            r_state <= R_WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        R_WAIT: begin
          // Nonblocking memory update means a same-edge commit is not seen here.
          if (r_cnt == '0) begin
            rdata   <= r_in_range ? mem[r_idx[MEM_AW-1:0]] : 32'h0;
            rresp   <= r_in_range ? 2'b00 : 2'b11;
            rvalid  <= 1'b1;
            r_state <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      w_idx   <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_cnt   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_idx   <= awaddr[ADDR_WIDTH-1:2];
            aw_got  <= 1'b1;
            awready <= 1'b0;
          end else if (!aw_got) begin
            awready <= 1'b1;
          end
          if (wvalid && wready) begin
            w_data <= wdata;
            w_strb <= wstrb;
            w_got  <= 1'b1;
            wready <= 1'b0;
          end else if (!w_got) begin
            wready <= 1'b1;
          end
          if (aw_now && w_now) begin
            w_cnt   <= WCW'(WR_LAT - 1);
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt == '0) begin
            bresp   <= w_in_range ? 2'b00 : 2'b11;
            bvalid  <= 1'b1;
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 1'b1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset mid-write leaves the FSM idle so commit stays low.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[w_idx[MEM_AW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axil_sram_slave.sv
// Bench for axil_sram_slave: a latency-1 instance for most scenarios and a
// slower instance for latency and backpressure checks.
module tb_axil_sram_slave;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        arvalid = 0, awvalid = 0, wvalid = 0, rready = 0, bready = 0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        b_arvalid = 0, b_awvalid = 0, b_wvalid = 0;
  logic        b_arready, b_rvalid, b_awready, b_wready, b_bvalid;
  logic [31:0] b_rdata;
  logic [1:0]  b_rresp, b_bresp;

  logic [31:0] model_mem [int];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axil_sram_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .WR_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axil_sram_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .RD_LAT(4), .WR_LAT(3)) dut4 (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(b_arvalid), .arready(b_arready),
    .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(b_awvalid), .awready(b_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(b_wvalid), .wready(b_wready),
    .bresp(b_bresp), .bvalid(b_bvalid), .bready(bready)
  );

  // ---------------- reference model ----------------
  function automatic bit addr_ok(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!addr_ok(a)) return 32'h0;
    return model_mem[int'(a >> 2)];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    int k;
    if (!addr_ok(a)) return;
    k = int'(a >> 2);
    model_mem[k] = merge(model_mem.exists(k) ? model_mem[k] : 32'h0, d, s);
  endfunction

  // ---------------- driver tasks (drive and sample on negedge) ----------------
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1; rready = 1; n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 0; lat = 0;
    while (!rvalid && lat < 100) begin @(negedge clk); lat++; end
    total++;
    if (!rvalid) begin bad++; $display("FAIL rd_timeout addr=%h rvalid=%b want 1", addr, rvalid); end
    data = rdata; resp = rresp;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay, input int w_delay,
                           output logic [1:0] resp, output int blat,
                           output bit aw_stalled, output bit w_dropped);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    cyc = 0; aw_done = 0; w_done = 0; aw_stalled = 0; w_dropped = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 100) begin
      if (!aw_done && cyc >= aw_delay) awvalid = 1;
      if (!w_done && cyc >= w_delay) wvalid = 1;
      if (!aw_done && !awready) aw_stalled = 1;
      if (w_done && !aw_done && !wready) w_dropped = 1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (aw_hs) begin aw_done = 1; awvalid = 0; end
      if (w_hs) begin w_done = 1; wvalid = 0; end
    end
    total++;
    if (!(aw_done && w_done)) begin
      bad++; $display("FAIL wr_accept_timeout addr=%h aw=%b w=%b want 1 1", addr, aw_done, w_done);
    end
    bready = 1; blat = 0;
    while (!bvalid && blat < 100) begin @(negedge clk); blat++; end
    total++;
    if (!bvalid) begin bad++; $display("FAIL wr_b_timeout addr=%h bvalid=%b want 1", addr, bvalid); end
    resp = bresp;
    @(negedge clk);
    bready = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({arready, awready, wready, b_arready, b_awready, b_wready} !== 6'b0) begin
      bad++; $display("FAIL reset_readies got=%b want 000000",
                      {arready, awready, wready, b_arready, b_awready, b_wready});
    end
    total++;
    if ({rvalid, bvalid, rresp, bresp, rdata} !== 38'h0) begin
      bad++; $display("FAIL reset_outputs rvalid=%b bvalid=%b rresp=%b bresp=%b rdata=%h want all 0",
                      rvalid, bvalid, rresp, bresp, rdata);
    end
    rst = 0;
    @(negedge clk);
    total++;
    if ({arready, awready, wready, b_arready, b_awready, b_wready} !== 6'b111111) begin
      bad++; $display("FAIL release_readies got=%b want 111111",
                      {arready, awready, wready, b_arready, b_awready, b_wready});
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] d; logic [1:0] r; int lat; bit s1, s2;
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r, lat, s1, s2);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    total++;
    if (r !== 2'b00 || lat !== 1) begin
      bad++; $display("FAIL basic_write resp=%b lat=%0d want 00 1", r, lat);
    end
    axi_read(32'h10, d, r, lat);
    total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 1) begin
      bad++; $display("FAIL basic_read data=%h resp=%b lat=%0d want deadbeef 00 1", d, r, lat);
    end
    axi_read(32'h13, d, r, lat);
    total++;
    if (d !== model_read(32'h13) || r !== 2'b00) begin
      bad++; $display("FAIL misaligned_read data=%h resp=%b want %h 00", d, r, model_read(32'h13));
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int lat; bit s1, s2;
    axi_write(32'h8, 32'h11223344, 4'hF, 0, 0, r, lat, s1, s2);
    model_write(32'h8, 32'h11223344, 4'hF);
    axi_write(32'h8, 32'hAABBCCDD, 4'b0101, 0, 0, r, lat, s1, s2);
    model_write(32'h8, 32'hAABBCCDD, 4'b0101);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL strobe_bresp got=%b want 00", r); end
    axi_read(32'h8, d, r, lat);
    total++;
    if (d !== 32'h11BB33DD || d !== model_read(32'h8)) begin
      bad++; $display("FAIL strobe_read got=%h want 11bb33dd", d);
    end
    axi_write(32'h8, 32'hFFFFFFFF, 4'h0, 0, 0, r, lat, s1, s2);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL zero_strb_bresp got=%b want 00", r); end
    axi_read(32'h8, d, r, lat);
    total++;
    if (d !== 32'h11BB33DD) begin bad++; $display("FAIL zero_strb_read got=%h want 11bb33dd", d); end
  endtask

  task automatic test_channel_order();
    logic [31:0] d, v; logic [1:0] r; int lat; bit aw_st, w_dr;
    v = $urandom();
    axi_write(32'h14, v, 4'hF, 3, 0, r, lat, aw_st, w_dr);
    model_write(32'h14, v, 4'hF);
    total++;
    if (w_dr !== 1'b1 || aw_st !== 1'b0) begin
      bad++; $display("FAIL w_first_readies wready_dropped=%b awready_dropped=%b want 1 0", w_dr, aw_st);
    end
    total++;
    if (r !== 2'b00 || lat !== 1 || bvalid !== 1'b0) begin
      bad++; $display("FAIL w_first_b resp=%b lat=%0d bvalid_after=%b want 00 1 0", r, lat, bvalid);
    end
    axi_read(32'h14, d, r, lat);
    total++;
    if (d !== model_read(32'h14)) begin bad++; $display("FAIL w_first_read got=%h want %h", d, v); end
    v = $urandom();
    axi_write(32'h18, v, 4'hF, 0, 2, r, lat, aw_st, w_dr);
    model_write(32'h18, v, 4'hF);
    axi_read(32'h18, d, r, lat);
    total++;
    if (d !== model_read(32'h18) || r !== 2'b00) begin
      bad++; $display("FAIL aw_first_read got=%h resp=%b want %h 00", d, r, v);
    end
  endtask

  task automatic test_rd_lat4();
    logic [31:0] v; int lat; bit stable;
    v = $urandom();
    @(negedge clk);
    awaddr = 32'h40; wdata = v; wstrb = 4'hF; b_awvalid = 1; b_wvalid = 1;
    @(negedge clk);
    b_awvalid = 0; b_wvalid = 0; bready = 1; lat = 0;
    while (!b_bvalid && lat < 100) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 3 || b_bresp !== 2'b00) begin
      bad++; $display("FAIL lat3_write blat=%0d bresp=%b want 3 00", lat, b_bresp);
    end
    @(negedge clk);
    bready = 0; araddr = 32'h40; b_arvalid = 1; rready = 0;
    @(negedge clk);
    b_arvalid = 0; lat = 0;
    while (!b_rvalid && lat < 100) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL lat4_rvalid lat=%0d want 4", lat); end
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      if (b_rvalid !== 1'b1 || b_rdata !== v || b_rresp !== 2'b00 || b_arready !== 1'b0) stable = 0;
      @(negedge clk);
    end
    total++;
    if (!stable || b_rdata !== v) begin
      bad++; $display("FAIL lat4_hold rdata=%h rvalid=%b arready=%b want %h 1 0", b_rdata, b_rvalid, b_arready, v);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    total++;
    if (b_rvalid !== 1'b0 || b_arready !== 1'b1) begin
      bad++; $display("FAIL lat4_release rvalid=%b arready=%b want 0 1", b_rvalid, b_arready);
    end
  endtask

  task automatic test_decerr();
    logic [31:0] d, v; logic [1:0] r; int lat; bit s1, s2;
    v = $urandom();
    axi_write(32'h0, v, 4'hF, 0, 0, r, lat, s1, s2);
    model_write(32'h0, v, 4'hF);
    axi_read(32'(4 * DEPTH), d, r, lat);
    total++;
    if (r !== 2'b11 || d !== 32'h0) begin
      bad++; $display("FAIL oor_read resp=%b data=%h want 11 00000000", r, d);
    end
    axi_write(32'(4 * DEPTH), ~v, 4'hF, 0, 0, r, lat, s1, s2);
    total++;
    if (r !== 2'b11) begin bad++; $display("FAIL oor_write bresp=%b want 11", r); end
    axi_read(32'h0, d, r, lat);
    total++;
    if (d !== model_read(32'h0)) begin bad++; $display("FAIL oor_no_alias word0=%h want %h", d, v); end
  endtask

  task automatic test_collision();
    logic [31:0] d, a_val, b_val; logic [1:0] r; int lat; bit s1, s2;
    a_val = $urandom(); b_val = ~a_val;
    axi_write(32'h24, a_val, 4'hF, 0, 0, r, lat, s1, s2);
    model_write(32'h24, a_val, 4'hF);
    @(negedge clk);
    araddr = 32'h24; awaddr = 32'h24; wdata = b_val; wstrb = 4'hF;
    arvalid = 1; awvalid = 1; wvalid = 1; rready = 1; bready = 1;
    @(negedge clk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    @(negedge clk);
    total++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== model_read(32'h24)) begin
      bad++; $display("FAIL collision rvalid=%b bvalid=%b rdata=%h want 1 1 %h", rvalid, bvalid, rdata, a_val);
    end
    model_write(32'h24, b_val, 4'hF);
    @(negedge clk);
    rready = 0; bready = 0;
    axi_read(32'h24, d, r, lat);
    total++;
    if (d !== model_read(32'h24)) begin bad++; $display("FAIL collision_after got=%h want %h", d, b_val); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d, v; logic [1:0] r; int lat; bit s1, s2, quiet;
    v = $urandom();
    axi_write(32'h1C, v, 4'hF, 0, 0, r, lat, s1, s2);
    model_write(32'h1C, v, 4'hF);
    @(negedge clk);
    araddr = 32'h1C; awaddr = 32'h1C; wdata = ~v; wstrb = 4'hF;
    arvalid = 1; awvalid = 1; wvalid = 1; rready = 1; bready = 1;
    @(negedge clk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    total++;
    if ({arready, awready, wready} !== 3'b000) begin
      bad++; $display("FAIL abort_accepted readies=%b want 000", {arready, awready, wready});
    end
    rst = 1;
    quiet = 1;
    repeat (3) begin @(negedge clk); if (rvalid !== 1'b0 || bvalid !== 1'b0) quiet = 0; end
    rst = 0;
    @(negedge clk);
    if (rvalid !== 1'b0 || bvalid !== 1'b0) quiet = 0;
    total++;
    if (!quiet) begin bad++; $display("FAIL abort_no_response rvalid=%b bvalid=%b want 0 0", rvalid, bvalid); end
    total++;
    if ({arready, awready, wready} !== 3'b111) begin
      bad++; $display("FAIL abort_readies got=%b want 111", {arready, awready, wready});
    end
    rready = 0; bready = 0;
    axi_read(32'h1C, d, r, lat);
    total++;
    if (d !== model_read(32'h1C)) begin bad++; $display("FAIL abort_no_commit got=%h want %h", d, v); end
  endtask

  task automatic test_random();
    logic [31:0] d, a, v, e; logic [1:0] r, er; logic [3:0] s; int lat, idx; bit s1, s2;
    for (int i = 0; i < 16; i++) begin
      v = $urandom();
      axi_write(32'(4 * (32 + i)), v, 4'hF, 0, 0, r, lat, s1, s2);
      model_write(32'(4 * (32 + i)), v, 4'hF);
    end
    for (int n = 0; n < 60; n++) begin
      idx = 32 + $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) idx = DEPTH + $urandom_range(0, 15);
      a = 32'(4 * idx + $urandom_range(0, 3));
      er = addr_ok(a) ? 2'b00 : 2'b11;
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom(); s = 4'($urandom_range(0, 15));
        axi_write(a, v, s, $urandom_range(0, 2), $urandom_range(0, 2), r, lat, s1, s2);
        model_write(a, v, s);
        total++;
        if (r !== er || lat !== 1) begin
          bad++; $display("FAIL rand_write addr=%h resp=%b lat=%0d want %b 1", a, r, lat, er);
        end
      end else begin
        exp_q.push_back(model_read(a));
        axi_read(a, d, r, lat);
        e = exp_q.pop_front();
        total++;
        if (d !== e || r !== er || lat !== 1) begin
          bad++; $display("FAIL rand_read addr=%h data=%h resp=%b lat=%0d want %h %b 1", a, d, r, lat, e, er);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_strobe();
    test_channel_order();
    test_rd_lat4();
    test_decerr();
    test_collision();
    test_reset_abort();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
